uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter: the next generation of the team's fixed 8-bit, one-clock-per-bit transmitter. It serialises `DATA_W`-bit words into asynchronous serial frames at a programmable bit period, with optional parity and one or two stop bits. Words arrive over a valid/ready handshake, so an upstream FIFO or CSR block can stream bytes back-to-back. The block sits between the host-side data path and the `uart_tx` pad.

## Interface
- `DATA_W`, default 8: data bits per frame; legal 5..9.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal >= 2.
- `i_clk` in, 1: the single clock.
- `i_rst` in, 1: asynchronous, active-high reset.
- `i_data` in, `DATA_W`: word to send; sampled only on accept.
- `i_valid` in, 1: `i_data` is valid.
- `o_ready` out, 1: the block can accept a word.
- `i_parity` in, 2: parity mode, sampled on accept. 00 = none, 01 = even, 10 = odd, 11 = none (reserved).
- `i_stop2` in, 1: 1 = two stop bits, 0 = one; sampled on accept.
- `o_uart_tx` out, 1: serial line, idle high, registered.
- `o_busy` out, 1: a frame is in progress (state != IDLE).
- `o_done` out, 1: one-cycle pulse when a frame completes.

## Operation
- Accept: `i_valid & o_ready` at a rising edge. `o_ready` = (state == IDLE).
- On accept, latch:
  - `i_data` into the shift register;
  - the parity bit: even = XOR of data; odd = ~XOR;
  - the parity mode and `i_stop2`;
  - clear the baud counter and the bit counter.
- `i_data`, `i_parity` and `i_stop2` changes after accept have no effect on the current frame.
- States and transitions (the state advances when the baud counter reaches `CLKS_PER_BIT-1`):
  - IDLE: line 1. Go to START on accept.
  - START: line 0, one bit period. Go to DATA.
  - DATA: line = shift[0], LSB first, `DATA_W` bit periods. Shift right at each bit boundary. Go to PARITY if parity is enabled, else STOP.
  - PARITY: line = the latched parity bit, one bit period. Go to STOP.
  - STOP: line 1, one or two bit periods. Go to IDLE and pulse `o_done`.
- Frame length = (1 + `DATA_W` + P + S) × `CLKS_PER_BIT` cycles, where P = 0 or 1 and S = 1 or 2.
- Counter widths:
  - baud counter is `$clog2(CLKS_PER_BIT)` bits and wraps to 0 at `CLKS_PER_BIT-1`;
  - bit counter is `$clog2(DATA_W+1)` bits and counts data bits, then is reused for stop bits.
- While busy, `i_valid` is ignored, nothing is sampled, and the upstream holds its word.
- Mode 11 behaves exactly as mode 00.

## Timing
- Reset values: state IDLE, `o_uart_tx` = 1, `o_ready` = 1, `o_busy` = 0, `o_done` = 0, all counters and the shift register 0.
- Reset asserted mid-frame: the line returns high asynchronously, the frame is dropped, and `o_done` does not pulse.
- Latency: accept at edge 0, so the start bit drives the line from cycle 1 (registered output).
- `o_done` is high in the first IDLE cycle after the last stop bit. `o_ready` is high in that same cycle.
- Back-to-back: a word accepted in the `o_done` cycle starts its start bit on the next cycle. The minimum inter-frame idle is 1 clock (this extends the stop bit).
- The parity bit is computed combinationally from `i_data` and registered at accept. No cycle is spent on it.

## Structure
- Package `uart_pkg`:
  - `uart_tx_state_e` enum (IDLE, START, DATA, PARITY, STOP);
  - `uart_parity_e` (NONE = 2'b00, EVEN = 2'b01, ODD = 2'b10);
  - the legal-range constants for `DATA_W`.
- Sub-module `uart_baud_gen`:
  - parameter `CLKS_PER_BIT`; inputs `i_clk`, `i_rst`, `i_clear`;
  - outputs `o_tick`, a one-cycle pulse at count `CLKS_PER_BIT-1`.
  - It will be reused by the receiver.
- Top level: the FSM, shift register, bit counter and output register. Parameter assertions check that `DATA_W` and `CLKS_PER_BIT` are in range.

## Test plan
- `DATA_W`=8, `CLKS_PER_BIT`=4, mode 00, `i_stop2`=0, send 0xA5 -> line holds each value for 4 cycles:
  - 0 (start), then data 1,0,1,0,0,1,0,1, then 1 (stop);
  - `o_done` on cycle 41; `o_busy` high on cycles 1..40.
- Mode 01, `i_stop2`=1, send 0x07 -> parity bit 1 after the data bits, then two stop bits; the frame is 48 cycles and `o_done` is on cycle 49.
- Mode 10, send 0x00 -> parity bit 1. Mode 11, send 0x00 -> no parity bit and a 40-cycle frame.
- Hold `i_valid` high with 0x55 then 0xC3 -> the second accept occurs in the `o_done` cycle, and its start bit follows after exactly one idle cycle. Changing `i_data` while busy does not corrupt the 0x55 frame.
- Assert `i_rst` during data bit 3 -> `o_uart_tx` goes to 1 immediately, and `o_ready`=1, `o_busy`=0. No `o_done`. The next word transmits correctly.
- `DATA_W`=5, `CLKS_PER_BIT`=2, mode 01, send 5'b10110 -> data 0,1,1,0,1, then parity 1, then stop. The frame is 16 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and legal parameter ranges for the UART transmit/receive blocks.
package uart_pkg;

    localparam int DATA_W_MIN       = 5;
    localparam int DATA_W_MAX       = 9;
    localparam int CLKS_PER_BIT_MIN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        EVEN = 2'b01,
        ODD  = 2'b10
    } uart_parity_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: pulses o_tick on the last clock of every serial bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: registered state uses <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count <= '0;
        end else if (i_clear || count == CNT_MAX) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign o_tick = (count == CNT_MAX);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: valid/ready word input, start + DATA_W bits + optional
// parity + one or two stop bits, each CLKS_PER_BIT clocks long.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        i_parity,
    input  logic              i_stop2,
    output logic              o_uart_tx,
    output logic              o_busy,
    output logic              o_done
);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
        $error("uart_tx_frame: DATA_W out of range");
    end
    if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_clks_per_bit
        $error("uart_tx_frame: CLKS_PER_BIT out of range");
    end

    localparam int               BIT_W    = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    uart_tx_state_e    state;
    logic [DATA_W-1:0] shift;
    logic [BIT_W-1:0]  bit_cnt;
    logic              par_en;
    logic              par_bit;
    logic              stop2;
    logic              tx;
    logic              done;
    logic              tick;
    logic              par_next;

    // Odd parity is the inverse of even parity over the same data bits.
    assign par_next = (^i_data) ^ (i_parity == ODD);

    // Holding the timer clear while idle aligns bit periods to the accept edge.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clear(state == IDLE),
        .o_tick (tick)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            stop2   <= 1'b0;
            tx      <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        shift   <= i_data;
                        par_bit <= par_next;
                        par_en  <= (i_parity == EVEN) || (i_parity == ODD);
                        stop2   <= i_stop2;
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx    <= shift[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift <= shift >> 1;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (par_en) begin
                                tx    <= par_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            tx      <= shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    // bit_cnt marks whether the first of two stop bits is done.
                    if (tick) begin
                        if (stop2 && bit_cnt == '0) begin
                            bit_cnt <= BIT_W'(1);
                        end else begin
                            bit_cnt <= '0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_ready   = (state == IDLE);
    assign o_busy    = (state != IDLE);
    assign o_uart_tx = tx;
    assign o_done    = done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench: two transmitter instances (8-bit/4 clk and 5-bit/2 clk),
// checked cycle by cycle against hand-written frame bit patterns.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst;

    logic [7:0] data_a;
    logic       valid_a;
    logic       ready_a;
    logic [1:0] par_a;
    logic       stop2_a;
    logic       tx_a;
    logic       busy_a;
    logic       done_a;

    logic [4:0] data_b;
    logic       valid_b;
    logic       ready_b;
    logic [1:0] par_b;
    logic       stop2_b;
    logic       tx_b;
    logic       busy_b;
    logic       done_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_data   (data_a),
        .i_valid  (valid_a),
        .o_ready  (ready_a),
        .i_parity (par_a),
        .i_stop2  (stop2_a),
        .o_uart_tx(tx_a),
        .o_busy   (busy_a),
        .o_done   (done_a)
    );

    uart_tx_frame #(.DATA_W(5), .CLKS_PER_BIT(2)) dut_b (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_data   (data_b),
        .i_valid  (valid_b),
        .o_ready  (ready_b),
        .i_parity (par_b),
        .i_stop2  (stop2_b),
        .o_uart_tx(tx_b),
        .o_busy   (busy_b),
        .o_done   (done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the word is accepted on the next rising edge.
    task automatic start_word(input bit which, input logic [8:0] data,
                              input logic [1:0] par, input logic stop2);
        check("ready_before_accept", which ? ready_b : ready_a, 1'b1);
        if (which) begin
            data_b  = data[4:0];
            par_b   = par;
            stop2_b = stop2;
            valid_b = 1'b1;
        end else begin
            data_a  = data[7:0];
            par_a   = par;
            stop2_a = stop2;
            valid_a = 1'b1;
        end
    endtask

    // bits[0] is the first bit on the line. In cycle 1 the inputs are
    // disturbed (valid to `hold`, new data, flipped mode unless holding).
    task automatic check_frame(input string name, input bit which,
                               input logic [15:0] bits, input int nbits,
                               input int cpb, input bit hold,
                               input logic [8:0] next_data);
        for (int n = 1; n <= nbits * cpb; n++) begin
            @(negedge clk);
            check($sformatf("%s_tx_c%0d", name, n), which ? tx_b : tx_a, bits[(n-1)/cpb]);
            check($sformatf("%s_busy_c%0d", name, n), which ? busy_b : busy_a, 1'b1);
            check($sformatf("%s_done_c%0d", name, n), which ? done_b : done_a, 1'b0);
            if (n == 1) begin
                if (which) begin
                    valid_b = hold;
                    data_b  = next_data[4:0];
                    if (!hold) begin
                        par_b   = ~par_b;
                        stop2_b = ~stop2_b;
                    end
                end else begin
                    valid_a = hold;
                    data_a  = next_data[7:0];
                    if (!hold) begin
                        par_a   = ~par_a;
                        stop2_a = ~stop2_a;
                    end
                end
            end
        end
        @(negedge clk);
        check({name, "_done"},  which ? done_b  : done_a,  1'b1);
        check({name, "_idle"},  which ? busy_b  : busy_a,  1'b0);
        check({name, "_ready"}, which ? ready_b : ready_a, 1'b1);
        check({name, "_line"},  which ? tx_b    : tx_a,    1'b1);
    endtask

    initial begin
        bit seen_done;

        rst     = 1'b1;
        data_a  = '0;
        valid_a = 1'b0;
        par_a   = 2'b00;
        stop2_a = 1'b0;
        data_b  = '0;
        valid_b = 1'b0;
        par_b   = 2'b00;
        stop2_b = 1'b0;

        #12;
        check("rst_tx",    tx_a,    1'b1);
        check("rst_ready", ready_a, 1'b1);
        check("rst_busy",  busy_a,  1'b0);
        check("rst_done",  done_a,  1'b0);
        check("rst_tx_b",  tx_b,    1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 0xA5, no parity, one stop bit
        start_word(1'b0, 9'h0A5, 2'b00, 1'b0);
        check_frame("a5", 1'b0, {1'b1, 8'hA5, 1'b0}, 10, 4, 1'b0, 9'h1FF);
        @(negedge clk);
        check("a5_done_one_cycle", done_a, 1'b0);

        // 0x07, even parity (three ones -> 1), two stop bits
        start_word(1'b0, 9'h007, 2'b01, 1'b1);
        check_frame("even07", 1'b0, {2'b11, 1'b1, 8'h07, 1'b0}, 12, 4, 1'b0, 9'h0FF);

        // 0x00, odd parity -> 1; accepted in the done cycle
        start_word(1'b0, 9'h000, 2'b10, 1'b0);
        check_frame("odd00", 1'b0, {1'b1, 1'b1, 8'h00, 1'b0}, 11, 4, 1'b0, 9'h0FF);
        @(negedge clk);

        // 0x00, reserved mode 11 behaves as no parity
        start_word(1'b0, 9'h000, 2'b11, 1'b0);
        check_frame("rsv00", 1'b0, {1'b1, 8'h00, 1'b0}, 10, 4, 1'b0, 9'h0FF);
        @(negedge clk);

        // Back-to-back: valid held, data changed to 0xC3 while 0x55 is on the line
        start_word(1'b0, 9'h055, 2'b00, 1'b0);
        check_frame("b2b55", 1'b0, {1'b1, 8'h55, 1'b0}, 10, 4, 1'b1, 9'h0C3);
        check_frame("b2bc3", 1'b0, {1'b1, 8'hC3, 1'b0}, 10, 4, 1'b0, 9'h000);
        @(negedge clk);

        // Reset during data bit 3 of 0xA5 (frame cycles 17..20)
        par_a   = 2'b00;
        stop2_a = 1'b0;
        start_word(1'b0, 9'h0A5, 2'b00, 1'b0);
        @(negedge clk);
        valid_a = 1'b0;
        repeat (16) @(negedge clk);
        check("pre_rst_bit3", tx_a, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tx",    tx_a,    1'b1);
        check("mid_rst_ready", ready_a, 1'b1);
        check("mid_rst_busy",  busy_a,  1'b0);
        check("mid_rst_done",  done_a,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done_a) seen_done = 1'b1;
        end
        check("mid_rst_no_done", seen_done, 1'b0);
        check("post_rst_idle_tx", tx_a, 1'b1);
        start_word(1'b0, 9'h03C, 2'b00, 1'b0);
        check_frame("post_rst3c", 1'b0, {1'b1, 8'h3C, 1'b0}, 10, 4, 1'b0, 9'h000);
        @(negedge clk);

        // 5-bit word 10110, even parity -> 1, two clocks per bit
        start_word(1'b1, 9'h016, 2'b01, 1'b0);
        check_frame("w5", 1'b1, {1'b1, 1'b1, 5'b10110, 1'b0}, 8, 2, 1'b0, 9'h01F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
